// File: rtl/iso7816_dir_pkg.sv
// rtl/iso7816_dir_pkg.sv - shared state encodings and character constants for the ISO7816 direction tracker
// Purpose: state constants of the tracker FSM and character framing counts.
// Ports: none (package).
package iso7816_dir_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RACE  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_CHAR  = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;

  // Start bit plus 8 data bits plus parity occupy 10 ETUs; bits 1..9 get strobes.
  localparam logic [3:0] CHAR_ETUS    = 4'd10;
  localparam logic [3:0] DATA_STROBES = 4'd9;

endpackage

// File: rtl/iso7816_etu_counter.sv
// rtl/iso7816_etu_counter.sv - ETU timebase producing half-ETU and full-ETU ticks
// Purpose: counts clocks from a load point; half_tick marks each mid-ETU, full_tick each ETU end.
// Ports:
//   clk, nReset  clock and asynchronous active-low reset
//   load         restart the count from 0 (first clock after load is clock 1 of the ETU)
//   run          0 holds the counter at 0 and suppresses ticks
//   period       clocks per ETU (>= 4)
//   half_tick    1 on clock floor(period/2) of each ETU
//   full_tick    1 on clock period of each ETU; the counter reloads to 0 there
module iso7816_etu_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             load,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  output logic             half_tick,
  output logic             full_tick
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] half_val;
  logic [WIDTH-1:0] last_val;

  // cnt holds (clocks elapsed in this ETU) - 1, so compare against value - 1.
  always_comb begin
    half_val = (period >> 1) - WIDTH'(1);
    last_val = period - WIDTH'(1);
  end

  assign half_tick = run && (cnt == half_val);
  assign full_tick = run && (cnt == last_val);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (load || !run || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/iso7816_direction_tracker.sv
// rtl/iso7816_direction_tracker.sv - passive ISO7816 sniffer sequencer deciding per-character drive direction
// Purpose: synchronizes the wire probe outputs, decides which side drove each start bit,
//   validates it at mid-ETU and frames the character and guard time.
// Optional feature macro: ISO7816_DIR_ERRSIG_EN (error-signal detection in the first guard ETU).
// Ports:
//   clk, nReset        clock, asynchronous active-low reset
//   termMon, cardMon   async probe outputs (terminal / card side of sio)
//   enable             0 forces IDLE and suppresses strobes
//   clocksPerEtu       clocks per ETU, latched when IDLE is left
//   raceWindow         max clocks between the two falling edges
//   guardEtus          extra guard ETUs after the 10 character ETUs
//   busy               1 outside IDLE
//   charStart          pulse: start bit confirmed at mid-ETU
//   dirIsTerm          1 terminal drove, 0 card drove; held until next charStart
//   collision          pulse: both edges in the same clock
//   lineFault          pulse: second side did not follow within raceWindow
//   bitStrobe          pulse at mid-bit of bits 1..9
//   sioSample          synchronized termMon captured with bitStrobe
//   errorSignal        pulse: error signal seen in the first guard ETU (0 when feature disabled)
module iso7816_direction_tracker
  import iso7816_dir_pkg::*;
#(
  parameter int DIVIDER_WIDTH = 16,
  parameter int RACE_WIDTH    = 4
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     termMon,
  input  logic                     cardMon,
  input  logic                     enable,
  input  logic [DIVIDER_WIDTH-1:0] clocksPerEtu,
  input  logic [RACE_WIDTH-1:0]    raceWindow,
  input  logic [3:0]               guardEtus,
  output logic                     busy,
  output logic                     charStart,
  output logic                     dirIsTerm,
  output logic                     collision,
  output logic                     lineFault,
  output logic                     bitStrobe,
  output logic                     sioSample,
  output logic                     errorSignal
);

  logic                     term_s1, term_s2, term_q;
  logic                     card_s1, card_s2, card_q;
  logic [2:0]               state;
  logic                     dir_next;
  logic [DIVIDER_WIDTH-1:0] per_q;
  logic [RACE_WIDTH-1:0]    rc;
  logic [3:0]               bc;
  logic [3:0]               gc;
  logic                     term_fall, card_fall;
  logic                     drv_low, opp_fall;
  logic                     load, half_tick, full_tick;

  // Equal-depth synchronizers keep the relative order of the two edges.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      term_s1 <= 1'b0; term_s2 <= 1'b0; term_q <= 1'b0;
      card_s1 <= 1'b0; card_s2 <= 1'b0; card_q <= 1'b0;
    end else begin
      term_s1 <= termMon; term_s2 <= term_s1; term_q <= term_s2;
      card_s1 <= cardMon; card_s2 <= card_s1; card_q <= card_s2;
    end
  end

  assign term_fall = term_q & ~term_s2;
  assign card_fall = card_q & ~card_s2;
  assign drv_low   = dir_next ? ~term_s2 : ~card_s2;
  assign opp_fall  = dir_next ? card_fall : term_fall;
  assign busy      = (state != ST_IDLE);
  assign load      = (state == ST_IDLE) && enable && (term_fall || card_fall);

  // The ETU timebase starts at the first falling edge, so the race phase eats into
  // the start-bit half ETU; raceWindow is expected to stay below half an ETU.
  iso7816_etu_counter #(.WIDTH(DIVIDER_WIDTH)) u_etu (
    .clk       (clk),
    .nReset    (nReset),
    .load      (load),
    .run       (busy),
    .period    (per_q),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

`ifdef ISO7816_DIR_ERRSIG_EN
  logic err_hold;
  logic opp_low;
  assign opp_low = dirIsTerm ? ~card_s2 : ~term_s2;
`else
  assign errorSignal = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      dir_next  <= 1'b0;
      per_q     <= '0;
      rc        <= '0;
      bc        <= '0;
      gc        <= '0;
      charStart <= 1'b0;
      dirIsTerm <= 1'b0;
      collision <= 1'b0;
      lineFault <= 1'b0;
      bitStrobe <= 1'b0;
      sioSample <= 1'b0;
`ifdef ISO7816_DIR_ERRSIG_EN
      errorSignal <= 1'b0;
      err_hold    <= 1'b0;
`endif
    end else begin
      charStart <= 1'b0;
      collision <= 1'b0;
      lineFault <= 1'b0;
      bitStrobe <= 1'b0;
`ifdef ISO7816_DIR_ERRSIG_EN
      errorSignal <= 1'b0;
`endif
      if (state == ST_IDLE) per_q <= clocksPerEtu;

      if (!enable) begin
        state <= ST_IDLE;
`ifdef ISO7816_DIR_ERRSIG_EN
        err_hold <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (term_fall && card_fall) begin
              collision <= 1'b1;
              dir_next  <= 1'b1;
              state     <= ST_START;
            end else if (term_fall) begin
              dir_next <= 1'b1;
              rc       <= RACE_WIDTH'(1);
              state    <= ST_RACE;
            end else if (card_fall) begin
              dir_next <= 1'b0;
              rc       <= RACE_WIDTH'(1);
              state    <= ST_RACE;
            end
          end
          ST_RACE: begin
            // rc counts clocks since the first edge; a follower at rc <= raceWindow is accepted.
            if (!drv_low) begin
              state <= ST_IDLE;
            end else if (opp_fall) begin
              state <= ST_START;
            end else if (rc >= raceWindow) begin
              lineFault <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              rc <= rc + RACE_WIDTH'(1);
            end
          end
          ST_START: begin
            if (half_tick) begin
              if (drv_low) begin
                charStart <= 1'b1;
                dirIsTerm <= dir_next;
                bc        <= '0;
                state     <= ST_CHAR;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_CHAR: begin
            if (half_tick && (bc != DATA_STROBES)) begin
              bitStrobe <= 1'b1;
              sioSample <= term_s2;
              bc        <= bc + 4'd1;
            end else if (full_tick && (bc == DATA_STROBES)) begin
              gc    <= '0;
              state <= (guardEtus == 4'd0) ? ST_IDLE : ST_GUARD;
            end
          end
          ST_GUARD: begin
`ifdef ISO7816_DIR_ERRSIG_EN
            if (err_hold) begin
              // Hold off until the receiver releases the line so its edge is not taken as a start bit.
              if (!opp_low) begin
                err_hold <= 1'b0;
                state    <= ST_IDLE;
              end
            end else if (half_tick && (gc == 4'd0) && opp_low) begin
              errorSignal <= 1'b1;
              err_hold    <= 1'b1;
            end else
`endif
            if (full_tick) begin
              if (gc == guardEtus - 4'd1) state <= ST_IDLE;
              else gc <= gc + 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iso7816_direction_tracker.sv
// tb/tb_iso7816_direction_tracker.sv - directed self-checking bench for iso7816_direction_tracker
module tb_iso7816_direction_tracker;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        term_mon = 1'b1;
  logic        card_mon = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] cpe = 16'd16;
  logic [3:0]  race_window = 4'd4;
  logic [3:0]  guard_etus = 4'd0;
  logic        busy, char_start, dir_is_term, collision, line_fault;
  logic        bit_strobe, sio_sample, error_signal;

  int errors = 0;
  int checks = 0;

  iso7816_direction_tracker dut (
    .clk          (clk),
    .nReset       (n_reset),
    .termMon      (term_mon),
    .cardMon      (card_mon),
    .enable       (enable),
    .clocksPerEtu (cpe),
    .raceWindow   (race_window),
    .guardEtus    (guard_etus),
    .busy         (busy),
    .charStart    (char_start),
    .dirIsTerm    (dir_is_term),
    .collision    (collision),
    .lineFault    (line_fault),
    .bitStrobe    (bit_strobe),
    .sioSample    (sio_sample),
    .errorSignal  (error_signal)
  );

  always #5 clk = ~clk;

  // Event monitor: counts and timestamps of every pulse, sampled on the falling edge.
  int   cyc = 0;
  int   cs_n = 0, col_n = 0, lf_n = 0, es_n = 0, bs_n = 0;
  int   cs_cyc = 0, col_cyc = 0, lf_cyc = 0, es_cyc = 0, bf_cyc = 0;
  int   bs_cyc[$];
  logic bs_val[$];
  logic busy_q = 1'b0;
  int   t_drv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_q <= busy;
    if (busy_q && !busy) bf_cyc <= cyc;
    if (char_start) begin cs_n <= cs_n + 1; cs_cyc <= cyc; end
    if (collision) begin col_n <= col_n + 1; col_cyc <= cyc; end
    if (line_fault) begin lf_n <= lf_n + 1; lf_cyc <= cyc; end
    if (error_signal) begin es_n <= es_n + 1; es_cyc <= cyc; end
    if (bit_strobe) begin
      bs_n <= bs_n + 1;
      bs_cyc.push_back(cyc);
      bs_val.push_back(sio_sample);
    end
  end

  // Pipeline from driving an input to a registered pulse reacting to it:
  // two synchronizer flops, the edge detector cycle, then the output register.
  localparam int LAT = 3;

  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] data, input int k);
    logic [9:0] f;
    f = {1'b1, ^data, data};
    return f[k];
  endfunction

  // Drives a full character: start bit, 8 data LSB-first, even parity, stop; returns at the stop bit.
  task automatic send_char(input bit term_first, input int lag, input logic [7:0] data, input int per);
    @(posedge clk); #1;
    cpe = 16'(per);
    @(posedge clk); #1;
    if (term_first) term_mon = 1'b0; else card_mon = 1'b0;
    t_drv = cyc;
    if (lag > 0) wait_to(t_drv + lag);
    term_mon = 1'b0;
    card_mon = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      wait_to(t_drv + i * per);
      term_mon = frame_bit(data, i - 1);
      card_mon = frame_bit(data, i - 1);
    end
  endtask

  task automatic test_reset;
    n_reset = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (char_start !== 1'b0) begin errors++; $display("FAIL reset_charStart: got %b expected 0", char_start); end
    checks++; if (dir_is_term !== 1'b0) begin errors++; $display("FAIL reset_dirIsTerm: got %b expected 0", dir_is_term); end
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL reset_collision: got %b expected 0", collision); end
    checks++; if (line_fault !== 1'b0) begin errors++; $display("FAIL reset_lineFault: got %b expected 0", line_fault); end
    checks++; if (bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_bitStrobe: got %b expected 0", bit_strobe); end
    checks++; if (sio_sample !== 1'b0) begin errors++; $display("FAIL reset_sioSample: got %b expected 0", sio_sample); end
    checks++; if (error_signal !== 1'b0) begin errors++; $display("FAIL reset_errorSignal: got %b expected 0", error_signal); end
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy got %b expected 0", busy); end
  endtask

  task automatic test_term_first_372;
    int cs0, bs0, lf0, col0, bad;
    cs0 = cs_n; bs0 = bs_n; lf0 = lf_n; col0 = col_n;
    guard_etus = 4'd2;
    send_char(1'b1, 2, 8'hA5, 372);
    wait_to(t_drv + 12 * 372 + 40);
    checks++; if (cs_n - cs0 !== 1) begin errors++; $display("FAIL t1_charStart_count: got %0d expected 1", cs_n - cs0); end
    checks++; if (cs_cyc - t_drv !== LAT + 186) begin errors++; $display("FAIL t1_charStart_time: got %0d expected %0d", cs_cyc - t_drv, LAT + 186); end
    checks++; if (dir_is_term !== 1'b1) begin errors++; $display("FAIL t1_dirIsTerm: got %b expected 1", dir_is_term); end
    checks++; if (bs_n - bs0 !== 9) begin errors++; $display("FAIL t1_strobe_count: got %0d expected 9", bs_n - bs0); end
    if (bs_cyc.size() >= bs0 + 9) begin
      checks++; if (bs_cyc[bs0] - cs_cyc !== 372) begin errors++; $display("FAIL t1_first_strobe: got %0d expected 372", bs_cyc[bs0] - cs_cyc); end
      bad = 0;
      for (int k = 1; k < 9; k++) if (bs_cyc[bs0 + k] - bs_cyc[bs0 + k - 1] != 372) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL t1_strobe_spacing: got %0d bad gaps expected 0", bad); end
    end
    checks++; if (bf_cyc - t_drv !== LAT + 12 * 372) begin errors++; $display("FAIL t1_busy_end: got %0d expected %0d", bf_cyc - t_drv, LAT + 12 * 372); end
    checks++; if (lf_n - lf0 !== 0) begin errors++; $display("FAIL t1_lineFault: got %0d expected 0", lf_n - lf0); end
    checks++; if (col_n - col0 !== 0) begin errors++; $display("FAIL t1_collision: got %0d expected 0", col_n - col0); end
  endtask

  task automatic test_card_first_3b;
    int bs0, got, want;
    bs0 = bs_n;
    guard_etus = 4'd1;
    send_char(1'b0, 1, 8'h3B, 16);
    wait_to(t_drv + 11 * 16 + 20);
    checks++; if (dir_is_term !== 1'b0) begin errors++; $display("FAIL t2_dirIsTerm: got %b expected 0", dir_is_term); end
    checks++; if (bs_n - bs0 !== 9) begin errors++; $display("FAIL t2_strobe_count: got %0d expected 9", bs_n - bs0); end
    if (bs_val.size() >= bs0 + 9) begin
      for (int k = 0; k < 9; k++) begin
        got = int'(bs_val[bs0 + k]);
        want = int'(frame_bit(8'h3B, k));
        checks++; if (got !== want) begin errors++; $display("FAIL t2_sio_bit%0d: got %0d expected %0d", k + 1, got, want); end
      end
    end
  endtask

  task automatic test_collision;
    int cs0, col0;
    cs0 = cs_n; col0 = col_n;
    guard_etus = 4'd0;
    send_char(1'b1, 0, 8'h00, 16);
    wait_to(t_drv + 10 * 16 + 20);
    checks++; if (col_n - col0 !== 1) begin errors++; $display("FAIL t3_collision_count: got %0d expected 1", col_n - col0); end
    checks++; if (col_cyc - t_drv !== LAT) begin errors++; $display("FAIL t3_collision_time: got %0d expected %0d", col_cyc - t_drv, LAT); end
    checks++; if (cs_n - cs0 !== 1) begin errors++; $display("FAIL t3_charStart_count: got %0d expected 1", cs_n - cs0); end
    checks++; if (dir_is_term !== 1'b1) begin errors++; $display("FAIL t3_dirIsTerm: got %b expected 1", dir_is_term); end
  endtask

  task automatic test_faults_and_glitches;
    int cs0, lf0, col0;
    race_window = 4'd4;
    // Term falls, card never follows.
    cs0 = cs_n; lf0 = lf_n;
    @(posedge clk); #1;
    term_mon = 1'b0; t_drv = cyc;
    wait_to(t_drv + 20);
    term_mon = 1'b1;
    wait_to(t_drv + 30);
    checks++; if (lf_n - lf0 !== 1) begin errors++; $display("FAIL t4_lineFault_count: got %0d expected 1", lf_n - lf0); end
    checks++; if (lf_cyc - t_drv !== LAT + 4) begin errors++; $display("FAIL t4_lineFault_time: got %0d expected %0d", lf_cyc - t_drv, LAT + 4); end
    checks++; if (cs_n - cs0 !== 0) begin errors++; $display("FAIL t4_fault_charStart: got %0d expected 0", cs_n - cs0); end
    // Term dips for 2 clocks inside the race window: silent return to IDLE.
    lf0 = lf_n;
    term_mon = 1'b0; t_drv = cyc;
    wait_to(t_drv + 2);
    term_mon = 1'b1;
    wait_to(t_drv + 20);
    checks++; if (lf_n - lf0 !== 0) begin errors++; $display("FAIL t4_race_glitch_fault: got %0d expected 0", lf_n - lf0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_race_glitch_busy: got %b expected 0", busy); end
    // 100-clock low pulse on both sides, shorter than half an ETU.
    cs0 = cs_n; lf0 = lf_n; col0 = col_n;
    cpe = 16'd372;
    @(posedge clk); #1;
    term_mon = 1'b0; t_drv = cyc;
    wait_to(t_drv + 1);
    card_mon = 1'b0;
    wait_to(t_drv + 100);
    term_mon = 1'b1; card_mon = 1'b1;
    wait_to(t_drv + 400);
    checks++; if (cs_n - cs0 !== 0) begin errors++; $display("FAIL t4_pulse_charStart: got %0d expected 0", cs_n - cs0); end
    checks++; if (lf_n - lf0 + col_n - col0 !== 0) begin errors++; $display("FAIL t4_pulse_fault_collision: got %0d expected 0", lf_n - lf0 + col_n - col0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_pulse_busy: got %b expected 0", busy); end
    // Follower exactly at raceWindow is still accepted.
    cs0 = cs_n; lf0 = lf_n;
    guard_etus = 4'd0;
    send_char(1'b1, 4, 8'h00, 16);
    wait_to(t_drv + 10 * 16 + 20);
    checks++; if (cs_n - cs0 !== 1) begin errors++; $display("FAIL t4_lag_limit_charStart: got %0d expected 1", cs_n - cs0); end
    checks++; if (lf_n - lf0 !== 0) begin errors++; $display("FAIL t4_lag_limit_fault: got %0d expected 0", lf_n - lf0); end
  endtask

  task automatic test_enable_drop;
    int bs0, cs0, k, got, want;
    bs0 = bs_n; cs0 = cs_n;
    guard_etus = 4'd1;
    fork
      send_char(1'b1, 1, 8'h3B, 16);
      begin
        k = 0;
        while (bs_n < bs0 + 4 && k < 2000) begin @(posedge clk); k++; end
        checks++; if (k >= 2000) begin errors++; $display("FAIL t5_wait_bit4: got timeout expected 4 strobes"); end
        #1 enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_after_disable: got %b expected 0", busy); end
      end
    join
    wait_to(t_drv + 12 * 16);
    checks++; if (bs_n - bs0 !== 4) begin errors++; $display("FAIL t5_strobes_after_disable: got %0d expected 4", bs_n - bs0); end
    enable = 1'b1;
    wait_to(t_drv + 12 * 16 + 8);
    bs0 = bs_n; cs0 = cs_n;
    send_char(1'b1, 1, 8'h3B, 16);
    wait_to(t_drv + 11 * 16 + 20);
    checks++; if (cs_n - cs0 !== 1) begin errors++; $display("FAIL t5_next_charStart: got %0d expected 1", cs_n - cs0); end
    checks++; if (bs_n - bs0 !== 9) begin errors++; $display("FAIL t5_next_strobes: got %0d expected 9", bs_n - bs0); end
    if (bs_val.size() >= bs0 + 9) begin
      for (int j = 0; j < 9; j++) begin
        got = int'(bs_val[bs0 + j]);
        want = int'(frame_bit(8'h3B, j));
        checks++; if (got !== want) begin errors++; $display("FAIL t5_sio_bit%0d: got %0d expected %0d", j + 1, got, want); end
      end
    end
  endtask

  task automatic test_error_signal;
    int es0;
    es0 = es_n;
    guard_etus = 4'd2;
    send_char(1'b1, 1, 8'h55, 16);
    wait_to(t_drv + 10 * 16 + 2);
    card_mon = 1'b0;
    wait_to(t_drv + 10 * 16 + 14);
    card_mon = 1'b1;
    wait_to(t_drv + 13 * 16 + 20);
`ifdef ISO7816_DIR_ERRSIG_EN
    checks++; if (es_n - es0 !== 1) begin errors++; $display("FAIL t6_errsig_count: got %0d expected 1", es_n - es0); end
    checks++; if (es_cyc - t_drv !== LAT + 10 * 16 + 8) begin errors++; $display("FAIL t6_errsig_time: got %0d expected %0d", es_cyc - t_drv, LAT + 10 * 16 + 8); end
`else
    checks++; if (es_n - es0 !== 0) begin errors++; $display("FAIL t6_errsig_count: got %0d expected 0", es_n - es0); end
    checks++; if (bf_cyc - t_drv !== LAT + 12 * 16) begin errors++; $display("FAIL t6_guard_end: got %0d expected %0d", bf_cyc - t_drv, LAT + 12 * 16); end
`endif
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_end: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_term_first_372();
    test_card_first_3b();
    test_collision();
    test_faults_and_glitches();
    test_enable_drop();
    test_error_signal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
